// File: rtl/action_scheduler.sv
// action_scheduler: merges player action strobes and demo/hint requests into
// one paced, one-hot action stream for the play controller. Actions are
// buffered in a small FIFO (user before demo), each issue is followed by a
// cooldown, and the per-game step counter is maintained here. Leaving the
// GAMING state flushes everything that is pending.
module action_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int COOLDOWN   = 3,
  parameter int STEP_W     = 6
) (
  input  logic              clk_d,
  input  logic              rst,
  input  logic [1:0]        game_status,
  input  logic [3:0]        user_act,
  input  logic              demo_req,
  input  logic [3:0]        demo_act,
  output logic              demo_ack,
  output logic [3:0]        act_out,
  output logic              act_valid,
  output logic [STEP_W-1:0] step_count,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int COOL_LAST_I = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]      OCC_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

  localparam logic [1:0] GS_CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GS_GAMING       = 2'b01;
  localparam logic [1:0] GS_GAME_INITIAL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    COOL  = 2'd2
  } state_t;

  // A code is legal only when exactly one action bit is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Step counter stops at its maximum instead of wrapping.
  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + {{(STEP_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cool_cnt;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_nxt;

  logic             gaming;
  logic             fifo_empty;
  logic             full_now;
  logic             user_any;
  logic             user_push;
  logic             user_drop;
  logic             demo_push;
  logic             push;
  logic [3:0]       push_data;
  logic             pop;

  // Push/pop arbitration for the current edge; the full check uses the
  // pre-edge occupancy so a same-edge pop never frees room for a push.
  always_comb begin
    gaming     = (game_status == GS_GAMING);
    fifo_empty = (occ == '0);
    full_now   = (occ == DEPTH_CNT);
    user_any   = |user_act;
    user_push  = gaming && is_onehot(user_act) && !full_now;
    user_drop  = gaming && user_any && (!is_onehot(user_act) || full_now);
    demo_push  = gaming && !user_any && demo_req && is_onehot(demo_act) && !full_now;
    push       = user_push || demo_push;
    push_data  = user_push ? user_act : demo_act;
    pop        = gaming && (state == IDLE) && !fifo_empty;
    occ_nxt    = occ;
    if (!gaming)
      occ_nxt = '0;
    else if (push && !pop)
      occ_nxt = occ + OCC_ONE;
    else if (pop && !push)
      occ_nxt = occ - OCC_ONE;
  end

  // FIFO pointers and occupancy; everything is discarded outside GAMING.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      fifo_full <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      fifo_full <= (occ_nxt == DEPTH_CNT);
      if (!gaming) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_d) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Status pulses: demo acknowledge and discarded user action.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      demo_ack <= 1'b0;
      overflow <= 1'b0;
    end else begin
      demo_ack <= demo_push;
      overflow <= user_drop;
    end
  end

  // Issue FSM: one-cycle strobe, then COOLDOWN idle cycles; step counting.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cool_cnt   <= '0;
      act_out    <= 4'd0;
      act_valid  <= 1'b0;
      step_count <= '0;
    end else begin
      if ((game_status == GS_CHOSE_BOARD) || (game_status == GS_GAME_INITIAL))
        step_count <= '0;
      else if (gaming && (state == ISSUE))
        step_count <= sat_inc(step_count);

      if (!gaming) begin
        state     <= IDLE;
        cool_cnt  <= '0;
        act_out   <= 4'd0;
        act_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              act_out   <= mem[rd_ptr];
              act_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            act_out   <= 4'd0;
            act_valid <= 1'b0;
            cool_cnt  <= '0;
            state     <= (COOLDOWN == 0) ? IDLE : COOL;
          end
          COOL: begin
            if (cool_cnt == COOL_LAST)
              state <= IDLE;
            else
              cool_cnt <= cool_cnt + CNT_ONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Testbench for action_scheduler: directed scenarios plus random traffic,
// scored against a queue-based reference model of the scheduling rules.
module tb_action_scheduler;

  localparam int DEPTH    = 4;
  localparam int COOLDOWN = 3;
  localparam int STEP_W   = 6;
  localparam int STEP_MAX = (1 << STEP_W) - 1;

  logic              clk_d = 1'b0;
  logic              rst   = 1'b1;
  logic [1:0]        game_status = 2'b00;
  logic [3:0]        user_act = 4'd0;
  logic              demo_req = 1'b0;
  logic [3:0]        demo_act = 4'd0;
  logic              demo_ack;
  logic [3:0]        act_out;
  logic              act_valid;
  logic [STEP_W-1:0] step_count;
  logic              fifo_full;
  logic              overflow;

  action_scheduler #(.FIFO_DEPTH(DEPTH), .COOLDOWN(COOLDOWN), .STEP_W(STEP_W)) dut (
    .clk_d(clk_d), .rst(rst), .game_status(game_status), .user_act(user_act),
    .demo_req(demo_req), .demo_act(demo_act), .demo_ack(demo_ack),
    .act_out(act_out), .act_valid(act_valid), .step_count(step_count),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk_d = ~clk_d;

  typedef struct {
    logic [3:0] code;
    logic       ack;
    logic       ovf;
    logic       full;
    int         step;
  } exp_t;

  exp_t       cyc_q[$];
  logic [3:0] act_q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0] mq[$];
  int  t         = 0;
  int  next_free = 0;
  int  mstep     = 0;
  bit  pending   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One clock edge of the scheduling rules, written over a plain queue and
  // an "earliest next issue" time rather than explicit FSM states.
  task automatic model_edge(input logic [1:0] gs, input logic [3:0] ua,
                            input logic dr, input logic [3:0] da);
    exp_t e;
    bit   full_pre;
    bit   issue = 0;
    logic [3:0] code = 4'd0;
    logic [3:0] pushv = 4'd0;
    bit   do_push = 0;
    e.ack = 0;
    e.ovf = 0;
    full_pre = (mq.size() == DEPTH);
    if (gs == 2'b01) begin
      if (ua != 4'd0) begin
        if ($countones(ua) == 1 && !full_pre) begin do_push = 1; pushv = ua; end
        else e.ovf = 1;
      end else if (dr && $countones(da) == 1 && !full_pre) begin
        do_push = 1; pushv = da; e.ack = 1;
      end
      if (pending && mstep < STEP_MAX) mstep++;
      if (mq.size() > 0 && t >= next_free) begin
        code = mq.pop_front();
        issue = 1;
        next_free = t + 2 + COOLDOWN;
      end
      if (do_push) mq.push_back(pushv);
    end else begin
      mq.delete();
      next_free = t + 1;
      if (gs != 2'b11) mstep = 0;
    end
    pending = issue;
    e.code = code;
    e.full = (mq.size() == DEPTH);
    e.step = mstep;
    cyc_q.push_back(e);
    if (issue) act_q.push_back(code);
    t++;
  endtask

  task automatic cyc(input logic [1:0] gs, input logic [3:0] ua,
                     input logic dr, input logic [3:0] da);
    @(negedge clk_d);
    game_status = gs;
    user_act    = ua;
    demo_req    = dr;
    demo_act    = da;
    model_edge(gs, ua, dr, da);
    @(posedge clk_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b01, 4'd0, 1'b0, 4'd0);
  endtask

  // Monitor: compares every modelled edge, and pops the action stream
  // whenever the DUT presents a strobe.
  always @(posedge clk_d) begin
    #1;
    if (cyc_q.size() > 0) begin
      exp_t e;
      e = cyc_q.pop_front();
      chk("act_out", act_out, e.code);
      chk("act_valid", act_valid, (e.code != 4'd0));
      chk("demo_ack", demo_ack, e.ack);
      chk("overflow", overflow, e.ovf);
      chk("fifo_full", fifo_full, e.full);
      chk("step_count", step_count, e.step);
    end
    if (act_valid) begin
      if (act_q.size() == 0) chk("spurious_act", act_out, 0);
      else chk("act_order", act_out, act_q.pop_front());
    end
  end

  initial begin
    int r;
    logic [3:0] ua;
    logic [3:0] da;
    logic [1:0] gs;
    logic       dr;

    #3;
    chk("rst_act_out", act_out, 0);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_step", step_count, 0);
    chk("rst_demo_ack", demo_ack, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_full", fifo_full, 0);
    repeat (2) @(negedge clk_d);
    rst = 1'b0;

    cyc(2'b00, 4'd0, 1'b0, 4'd0);
    idle(3);

    // single action
    cyc(2'b01, 4'b0100, 1'b0, 4'd0);
    idle(8);

    // overflow burst
    cyc(2'b01, 4'b0001, 1'b0, 4'd0);
    cyc(2'b01, 4'b0010, 1'b0, 4'd0);
    cyc(2'b01, 4'b0100, 1'b0, 4'd0);
    cyc(2'b01, 4'b1000, 1'b0, 4'd0);
    cyc(2'b01, 4'b0001, 1'b0, 4'd0);
    cyc(2'b01, 4'b0010, 1'b0, 4'd0);
    idle(30);

    // arbitration: user wins, demo follows next cycle
    cyc(2'b01, 4'b1000, 1'b1, 4'b0001);
    cyc(2'b01, 4'b0000, 1'b1, 4'b0001);
    idle(15);

    // illegal codes
    cyc(2'b01, 4'b0011, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 4'd0, 1'b1, 4'b0110);
    idle(8);

    // flush in WINNED, then clear in GAME_INITIAL
    cyc(2'b01, 4'b0001, 1'b0, 4'd0);
    cyc(2'b01, 4'b0010, 1'b0, 4'd0);
    cyc(2'b01, 4'b0100, 1'b0, 4'd0);
    cyc(2'b01, 4'b1000, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) cyc(2'b11, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(2'b10, 4'd0, 1'b0, 4'd0);
    idle(5);

    // reset in the middle of an ISSUE strobe
    cyc(2'b01, 4'b0100, 1'b0, 4'd0);
    cyc(2'b01, 4'b0010, 1'b0, 4'd0);
    @(negedge clk_d);
    rst = 1'b1;
    #1;
    chk("midrst_act_out", act_out, 0);
    chk("midrst_act_valid", act_valid, 0);
    chk("midrst_step", step_count, 0);
    chk("midrst_fifo_full", fifo_full, 0);
    user_act = 4'd0;
    repeat (2) @(negedge clk_d);
    rst = 1'b0;
    mq.delete();
    act_q.delete();
    mstep = 0;
    pending = 0;
    next_free = t;
    cyc(2'b01, 4'b1000, 1'b0, 4'd0);
    idle(6);

    // saturation: keep the queue busy well past 63 issues
    for (int i = 0; i < 400; i++) begin
      ua = 4'b0001 << $urandom_range(0, 3);
      cyc(2'b01, ua, 1'b0, 4'd0);
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 9);
      ua = 4'd0;
      if (r >= 6 && r <= 8) ua = 4'b0001 << $urandom_range(0, 3);
      else if (r == 9) ua = 4'($urandom_range(0, 15));
      dr = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) < 8) da = 4'b0001 << $urandom_range(0, 3);
      else da = 4'($urandom_range(0, 15));
      gs = ($urandom_range(0, 99) < 95) ? 2'b01 : 2'($urandom_range(0, 3));
      cyc(gs, ua, dr, da);
    end

    idle(40);
    @(negedge clk_d);
    chk("act_q_drained", act_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
